// File: rtl/sram_queue_ctrl.sv
// FIFO controller backed by an external 1W/1R SRAM macro with a registered read port.
// A 2-entry output buffer absorbs the one-cycle read latency so dequeue sees a plain FIFO.
module sram_queue_ctrl #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 160
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_enq_valid,
  output logic                io_enq_ready,
  input  logic [DATA_W-1:0]   io_enq_bits,
  output logic                io_deq_valid,
  input  logic                io_deq_ready,
  output logic [DATA_W-1:0]   io_deq_bits,
  output logic [ADDR_W+1:0]   io_count,
  output logic [ADDR_W-1:0]   mem_W0_addr,
  output logic                mem_W0_en,
  output logic [DATA_W-1:0]   mem_W0_data,
  output logic [ADDR_W-1:0]   mem_R0_addr,
  output logic                mem_R0_en,
  input  logic [DATA_W-1:0]   mem_R0_data
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned COUNT_W = ADDR_W + 2;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  sram_cnt_q, sram_cnt_d;
  logic [CNT_W-1:0]  unfetched_q, unfetched_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        obuf_cnt_q, obuf_cnt_d;
  logic              obuf_head_q, obuf_head_d;
  logic              obuf_tail_q, obuf_tail_d;
  logic [DATA_W-1:0] obuf_q [2];

  logic       enq_fire_c;
  logic       deq_fire_c;
  logic       issue_c;
  logic       capture_c;
  logic [2:0] rd_demand_c;

  // Handshakes; enq_ready is purely registered so it has no input-to-output path
  assign io_enq_ready = (sram_cnt_q < CNT_W'(DEPTH));
  assign io_deq_valid = (obuf_cnt_q != 2'd0);
  assign io_deq_bits  = obuf_q[obuf_head_q];
  assign enq_fire_c   = io_enq_valid & io_enq_ready & ~reset;
  assign deq_fire_c   = io_deq_valid & io_deq_ready;
  assign capture_c    = inflight_q;
  assign io_count     = COUNT_W'(sram_cnt_q) + COUNT_W'(obuf_cnt_q);

  // Only issue a read when the buffer will have room for the returning data
  assign rd_demand_c = 3'(obuf_cnt_q) + 3'(inflight_q) - 3'(deq_fire_c);
  assign issue_c     = (unfetched_q != '0) && (rd_demand_c < 3'd2) && !reset;

  assign mem_W0_en   = enq_fire_c;
  assign mem_W0_addr = reset ? '0 : wr_ptr_q;
  assign mem_W0_data = io_enq_bits;
  assign mem_R0_en   = issue_c;
  assign mem_R0_addr = reset ? '0 : rd_ptr_q;

  // sram_cnt releases a slot only at capture so it cannot be overwritten while a read is in flight
  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_W'(enq_fire_c);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(issue_c);
    sram_cnt_d  = sram_cnt_q + CNT_W'(enq_fire_c) - CNT_W'(capture_c);
    unfetched_d = unfetched_q + CNT_W'(enq_fire_c) - CNT_W'(issue_c);
    inflight_d  = issue_c;
    obuf_cnt_d  = obuf_cnt_q + 2'(capture_c) - 2'(deq_fire_c);
    obuf_head_d = obuf_head_q ^ deq_fire_c;
    obuf_tail_d = obuf_tail_q ^ capture_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sram_cnt_q  <= '0;
      unfetched_q <= '0;
      inflight_q  <= 1'b0;
      obuf_cnt_q  <= '0;
      obuf_head_q <= 1'b0;
      obuf_tail_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sram_cnt_q  <= sram_cnt_d;
      unfetched_q <= unfetched_d;
      inflight_q  <= inflight_d;
      obuf_cnt_q  <= obuf_cnt_d;
      obuf_head_q <= obuf_head_d;
      obuf_tail_q <= obuf_tail_d;
    end
  end

  // Output buffer payload; occupancy is tracked separately so no reset is needed here
  always_ff @(posedge clock) begin
    if (capture_c && !reset) begin
      obuf_q[obuf_tail_q] <= mem_R0_data;
    end
  end

endmodule

// File: tb/tb_sram_queue_ctrl.sv
// Directed + random bench for sram_queue_ctrl with a behavioural SRAM macro and a FIFO scoreboard.
module tb_sram_queue_ctrl;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DW     = 160;

  logic              clock;
  logic              reset;
  logic              io_enq_valid;
  logic              io_enq_ready;
  logic [DW-1:0]     io_enq_bits;
  logic              io_deq_valid;
  logic              io_deq_ready;
  logic [DW-1:0]     io_deq_bits;
  logic [ADDR_W+1:0] io_count;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic              mem_W0_en;
  logic [DW-1:0]     mem_W0_data;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic              mem_R0_en;
  logic [DW-1:0]     mem_R0_data;

  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_enq = 0;
  int n_deq = 0;

  sram_queue_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready), .io_enq_bits(io_enq_bits),
    .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready), .io_deq_bits(io_deq_bits),
    .io_count(io_count),
    .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data),
    .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model: registered read; garbage on idle cycles so unrequested captures are visible
  always @(posedge clock) begin
    if (mem_W0_en) sram[mem_W0_addr] <= mem_W0_data;
    if (mem_R0_en) mem_R0_data <= sram[mem_R0_addr];
    else           mem_R0_data <= {$urandom, $urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, then score the settled handshakes before the posedge
  task automatic drive(input logic ev, input logic [DW-1:0] eb, input logic dr);
    logic [DW-1:0] exp;
    @(negedge clock);
    io_enq_valid = ev;
    io_enq_bits  = eb;
    io_deq_ready = dr;
    #1;
    chk("count", DW'(io_count), DW'(sb.size()));
    if (mem_W0_en && mem_R0_en) chk("wr_rd_same_addr", DW'(mem_W0_addr == mem_R0_addr), DW'(0));
    if (io_deq_valid && io_deq_ready) begin
      n_deq++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL deq_unexpected: observed %0h expected no dequeue", io_deq_bits);
      end else begin
        exp = sb.pop_front();
        chk("deq_bits", io_deq_bits, exp);
      end
    end
    if (io_enq_valid && io_enq_ready) begin
      sb.push_back(io_enq_bits);
      n_enq++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    io_enq_valid = 1'b0;
    io_enq_bits  = '0;
    io_deq_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 400 && sb.size() > 0; k++) drive(1'b0, '0, 1'b1);
    chk(tag, DW'(sb.size()), DW'(0));
  endtask

  initial begin
    int base;
    reset        = 1'b1;
    io_enq_valid = 1'b0;
    io_enq_bits  = '0;
    io_deq_ready = 1'b0;
    do_reset();

    chk("rst_enq_ready", DW'(io_enq_ready), DW'(1));
    chk("rst_deq_valid", DW'(io_deq_valid), DW'(0));
    chk("rst_count",     DW'(io_count),     DW'(0));
    chk("rst_w0_en",     DW'(mem_W0_en),    DW'(0));
    chk("rst_r0_en",     DW'(mem_R0_en),    DW'(0));

    // Single item latency
    drive(1'b1, DW'(8'hA5), 1'b1);
    chk("lat_w0_en",   DW'(mem_W0_en),   DW'(1));
    chk("lat_w0_addr", DW'(mem_W0_addr), DW'(0));
    drive(1'b0, '0, 1'b1);
    chk("lat_r0_en",   DW'(mem_R0_en),   DW'(1));
    chk("lat_r0_addr", DW'(mem_R0_addr), DW'(0));
    chk("lat_c1_valid", DW'(io_deq_valid), DW'(0));
    drive(1'b0, '0, 1'b1);
    chk("lat_c2_valid", DW'(io_deq_valid), DW'(0));
    drive(1'b0, '0, 1'b1);
    chk("lat_c3_valid", DW'(io_deq_valid), DW'(1));
    chk("lat_c3_bits",  io_deq_bits, DW'(8'hA5));
    drain("lat_drain");

    // Fill with consumer stalled: capacity DEPTH+2
    do_reset();
    base = n_enq;
    for (int i = 0; i < 70; i++) drive(1'b1, DW'(i), 1'b0);
    chk("fill_accepted", DW'(n_enq - base), DW'(DEPTH + 2));
    drive(1'b0, '0, 1'b1);
    chk("full_count",      DW'(io_count),     DW'(DEPTH + 2 - 1 + 1));
    chk("full_pop_ready",  DW'(io_enq_ready), DW'(0));
    drive(1'b0, '0, 1'b1);
    chk("full_pop1_ready", DW'(io_enq_ready), DW'(0));
    drive(1'b0, '0, 1'b1);
    chk("full_pop2_ready", DW'(io_enq_ready), DW'(1));
    drain("fill_drain");

    // Sustained throughput across several pointer wraps
    do_reset();
    base = n_deq;
    for (int i = 0; i < 300; i++) drive(1'b1, DW'(i + 1000), 1'b1);
    chk("thru_deq", DW'(n_deq - base), DW'(297));
    drain("thru_drain");

    // Random traffic
    do_reset();
    for (int i = 0; i < 5000; i++)
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)));
    drain("rand_drain");

    // Reset while a read is in flight
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, DW'(i + 50), 1'b0);
    drive(1'b0, '0, 1'b1);
    chk("mid_issue", DW'(mem_R0_en), DW'(1));
    do_reset();
    chk("mid_count", DW'(io_count),     DW'(0));
    chk("mid_valid", DW'(io_deq_valid), DW'(0));
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
    chk("mid_idle_valid", DW'(io_deq_valid), DW'(0));
    drive(1'b1, DW'(1), 1'b1);
    drain("mid_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_queue_ctrl.md
# sram_queue_ctrl

Decoupled FIFO controller that stores its payload in an external 1-write/1-read SRAM macro of the `*_ext` family. It drives the macro's write port (`W0_*`) and read port (`R0_*`) and hides the macro's registered-address read behind a 2-entry output buffer. The macro's `R0_data` is only valid the cycle after `R0_en`. Sits between a producer and consumer as a large-capacity queue; the macro is instantiated alongside it, with `W0_clk`/`R0_clk` tied to `clock`.

## Interface
Parameters:
- `DEPTH`, 64 — SRAM entries; must be a power of two.
- `ADDR_W`, 6 — log2(`DEPTH`).
- `DATA_W`, 160 — payload width.

Ports:
- `clock` in 1 — single clock for the block and the macro.
- `reset` in 1 — synchronous, active-high.
- `io_enq_valid` in 1 — producer has data.
- `io_enq_ready` out 1 — queue accepts data.
- `io_enq_bits` in `DATA_W` — enqueued payload.
- `io_deq_valid` out 1 — head payload available.
- `io_deq_ready` in 1 — consumer takes head.
- `io_deq_bits` out `DATA_W` — head payload.
- `io_count` out `ADDR_W`+2 — total occupancy, 0..`DEPTH`+2.
- `mem_W0_addr` out `ADDR_W`, `mem_W0_en` out 1, `mem_W0_data` out `DATA_W` — macro write port.
- `mem_R0_addr` out `ADDR_W`, `mem_R0_en` out 1 — macro read request.
- `mem_R0_data` in `DATA_W` — macro read data, valid the cycle after `mem_R0_en`.

## Operation
State registers:
- `wr_ptr`, `rd_ptr` — `ADDR_W` bits, wrap modulo `DEPTH`.
- `sram_cnt` — 0..`DEPTH`; entries written and not yet captured.
- `unfetched` — 0..`DEPTH`; entries written and not yet read-issued.
- `inflight` — 1 bit.
- Output buffer — 2-entry ring; `obuf_cnt` 0..2, head/tail index.

Enqueue:
- `io_enq_ready` = (`sram_cnt` < `DEPTH`), from registers only.
- On enq fire: `mem_W0_en`=1, `mem_W0_addr`=`wr_ptr`, `mem_W0_data`=`io_enq_bits`.
- Then `wr_ptr`++, `sram_cnt`++, `unfetched`++.
- Non-fire cycles: `mem_W0_en`=0.

Read issue:
- `mem_R0_en` = (`unfetched`>0) && (`obuf_cnt` + `inflight` − deq_fire < 2), where deq_fire = `io_deq_valid`&`io_deq_ready`.
- `mem_R0_addr`=`rd_ptr`.
- On issue: `rd_ptr`++, `unfetched`−−, `inflight`←1; otherwise `inflight`←0.
- An entry written in cycle t is not counted in `unfetched` until edge t+1, so it is never read in the cycle it is written.

Capture:
- While `inflight`=1, `mem_R0_data` is pushed into the output buffer tail.
- `sram_cnt` decrements at this point, not at issue, so the slot cannot be overwritten before capture.

Dequeue:
- `io_deq_valid` = (`obuf_cnt`>0); `io_deq_bits` = buffer head.
- Deq fire pops the head.
- Capture and pop in the same cycle leave `obuf_cnt` unchanged.

Count and simultaneous events:
- `io_count` = `sram_cnt` + `obuf_cnt`.
- Simultaneous enq and capture leave `sram_cnt` unchanged; likewise `unfetched` under simultaneous enq and issue.
- Capacity is `DEPTH`+2 when the consumer stalls.

Reset (also mid-operation):
- All pointers and counters go to 0, `inflight`=0, contents discarded.
- Read data returning the cycle after reset is ignored.
- Output values during/after reset: `io_enq_ready`=1, `io_deq_valid`=0, `io_count`=0, `mem_W0_en`=0, `mem_R0_en`=0, addresses 0.

## Timing
- Enq-to-deq latency into an empty queue is 3 cycles: enq in cycle 0, write commits at edge 1, read issue in cycle 1, `R0_data` valid and captured in cycle 2, `io_deq_valid`=1 in cycle 3.
- Sustained throughput is 1 item/cycle with both sides always ready.
- `io_enq_ready` has no combinational path from any input.
- `mem_R0_en` depends combinationally on `io_deq_ready`.
- Full with `io_deq_ready`=1: `io_enq_ready` stays 0 in the pop cycle. It rises after the capture that follows the resulting read issue.
- Ordering is strict FIFO across pointer wrap.

## Test plan
- Reset -> `io_enq_ready`=1, `io_deq_valid`=0, `io_count`=0, `mem_W0_en`=`mem_R0_en`=0.
- Single enq of 0xA5 in cycle 0 (`io_deq_ready`=1) -> `mem_W0_en`=1 @ addr 0 in cycle 0; `mem_R0_en`=1 @ addr 0 in cycle 1; `io_deq_valid`=1 with bits 0xA5 in cycle 3.
- `io_deq_ready`=0, enq every cycle of values 0..N -> exactly 66 accepted, `io_count`=66, `io_enq_ready`=0; then drain -> values 0..65 in order.
- Both sides ready for 300 cycles with an incrementing pattern -> after 3-cycle fill, one deq per cycle; ordering preserved across ≥4 pointer wraps.
- Random `io_enq_valid`/`io_deq_ready` (50%) for 5000 cycles -> scoreboard order match; `io_count` equals the model; no write to an address whose read is issued but not yet captured.
- Assert `reset` one cycle after a read issue with 10 entries queued -> next cycle `io_count`=0, `io_deq_valid`=0; stale `R0_data` not captured; fresh enq of 0x1 dequeues as 0x1.
